// File: rtl/div_pkg.sv
// Shared definitions for the sequential 16-by-8 divider family.
//   state_t    : controller states (IDLE, CALC, DONE)
//   DW, QW     : dividend width and quotient/divisor/remainder width
//   QOVF, ROVF : quotient/remainder reported when the result cannot fit
package div_pkg;

  localparam int DW = 16;
  localparam int QW = 8;

  localparam logic [QW-1:0] QOVF = 8'hFF;
  localparam logic [QW-1:0] ROVF = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration, purely combinational.
//   p        : current partial remainder, always < divisor
//   next_bit : next dividend bit, MSB first
//   divisor  : divisor
//   p_next   : updated partial remainder, still < divisor
//   q_bit    : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
(
  input  logic [QW-1:0] p,
  input  logic          next_bit,
  input  logic [QW-1:0] divisor,
  output logic [QW-1:0] p_next,
  output logic          q_bit
);

  logic [QW:0]   trial;
  logic [QW-1:0] diff;

  // The trial value needs 9 bits so the compare never wraps.
  assign trial = {p, next_bit};
  assign q_bit = (trial >= {1'b0, divisor});

  // When the subtraction is taken the true result is below the divisor, so
  // it fits in 8 bits and the low byte of the difference is exact.
  assign diff   = trial[QW-1:0] - divisor;
  assign p_next = q_bit ? diff : trial[QW-1:0];

endmodule

// File: rtl/approx_div16by8_seq.sv
// Sequential 16-by-8 unsigned restoring divider with optional skipping of
// the low APPROX_BITS quotient bits (forced to zero) to shorten latency.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : operand handshake (ready only in IDLE)
//   dividend, divisor    : unsigned operands
//   out_valid, out_ready : result handshake (valid only in DONE)
//   quotient, remainder  : result, held stable while out_valid is high
//   ovf                  : quotient does not fit in 8 bits, or divisor == 0
// APPROX_BITS must lie in 0..7.
module approx_div16by8_seq
  import div_pkg::*;
#(
  parameter int APPROX_BITS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [QW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic [QW-1:0] remainder,
  output logic          ovf
);

  localparam int         N_ITER = QW - APPROX_BITS;
  localparam logic [3:0] LAST   = 4'(N_ITER - 1);

  state_t        state_q, state_d;
  logic [QW-1:0] divisor_q;
  logic [QW-1:0] p_q;
  logic [QW-1:0] shift_q;
  logic [QW-1:0] q_bits_q;
  logic [3:0]    cnt_q;
  logic [QW-1:0] quotient_q;
  logic [QW-1:0] remainder_q;
  logic          ovf_q;

  logic          accept;
  logic          too_big;
  logic          last_iter;
  logic [QW-1:0] step_p;
  logic          step_q;
  logic [QW-1:0] q_next;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  // Covers divisor == 0 as well: any high byte is >= 0.
  assign too_big   = (dividend[DW-1:QW] >= divisor);
  assign last_iter = (cnt_q == LAST);
  assign q_next    = {q_bits_q[QW-2:0], step_q};

  div_step u_step (
    .p        (p_q),
    .next_bit (shift_q[QW-1]),
    .divisor  (divisor_q),
    .p_next   (step_p),
    .q_bit    (step_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this block free of latches on
  // every path through the case.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)    state_d = too_big ? DONE : CALC;
      CALC: if (last_iter) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor_q   <= '0;
      p_q         <= '0;
      shift_q     <= '0;
      q_bits_q    <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            divisor_q <= divisor;
            if (too_big) begin
              quotient_q  <= QOVF;
              remainder_q <= ROVF;
              ovf_q       <= 1'b1;
            end else begin
              p_q      <= dividend[DW-1:QW];
              shift_q  <= dividend[QW-1:0];
              q_bits_q <= '0;
              cnt_q    <= '0;
            end
          end
        end
        CALC: begin
          p_q      <= step_p;
          shift_q  <= {shift_q[QW-2:0], 1'b0};
          q_bits_q <= q_next;
          cnt_q    <= cnt_q + 4'd1;
          if (last_iter) begin
            // Only N_ITER bits were computed; they occupy the upper positions.
            quotient_q  <= q_next << APPROX_BITS;
            remainder_q <= step_p;
            ovf_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_approx_div16by8_seq.sv
// Self-checking bench for approx_div16by8_seq: one instance with
// APPROX_BITS=0 and one with APPROX_BITS=2, checked against an arithmetic
// reference model.
module tb_approx_div16by8_seq;

  localparam int A_OF [2] = '{0, 2};

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        in_valid  [2];
  logic        out_ready [2];
  logic [15:0] dividend  [2];
  logic [7:0]  divisor   [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [7:0]  quotient  [2];
  logic [7:0]  remainder [2];
  logic        ovf       [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  approx_div16by8_seq #(.APPROX_BITS(0)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dividend(dividend[0]), .divisor(divisor[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .quotient(quotient[0]), .remainder(remainder[0]),
    .ovf(ovf[0])
  );

  approx_div16by8_seq #(.APPROX_BITS(2)) dut2 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dividend(dividend[1]), .divisor(divisor[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .quotient(quotient[1]), .remainder(remainder[1]),
    .ovf(ovf[1])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division of the truncated dividend.
  function automatic void model(input int a, input logic [15:0] dd, input logic [7:0] dv,
                                output logic [7:0] q, output logic [7:0] r, output logic o);
    int x;
    if (dd[15:8] >= dv) begin
      q = 8'hFF; r = 8'h00; o = 1'b1;
    end else begin
      x = int'(dd) >> a;
      q = 8'((x / int'(dv)) << a);
      r = 8'(x % int'(dv));
      o = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid; lat counts edges since the accepting edge.
  task automatic wait_valid(input int idx, output int lat);
    lat = 1;
    while (!out_valid[idx] && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic do_op(input int idx, input logic [15:0] dd, input logic [7:0] dv,
                       input int hold, input string tag);
    logic [7:0] eq, er;
    logic       eo;
    int         lat;
    model(A_OF[idx], dd, dv, eq, er, eo);
    check({tag, "_in_ready"}, 16'(in_ready[idx]), 16'd1);
    in_valid[idx] = 1'b1;
    dividend[idx] = dd;
    divisor[idx]  = dv;
    step();
    // Operand changes while busy must be ignored.
    in_valid[idx] = 1'($urandom_range(0, 1));
    dividend[idx] = 16'($urandom);
    divisor[idx]  = 8'($urandom);
    wait_valid(idx, lat);
    check({tag, "_latency"}, 16'(lat), eo ? 16'd1 : 16'(9 - A_OF[idx]));
    check({tag, "_quotient"}, 16'(quotient[idx]), 16'(eq));
    check({tag, "_remainder"}, 16'(remainder[idx]), 16'(er));
    check({tag, "_ovf"}, 16'(ovf[idx]), 16'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid[idx] = 1'b1;
      dividend[idx] = 16'($urandom);
      step();
      check({tag, "_hold_valid"}, 16'(out_valid[idx]), 16'd1);
      check({tag, "_hold_ready"}, 16'(in_ready[idx]), 16'd0);
      check({tag, "_hold_q"}, {quotient[idx], remainder[idx]}, {eq, er});
      check({tag, "_hold_ovf"}, 16'(ovf[idx]), 16'(eo));
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    step();
    out_ready[idx] = 1'b0;
    check({tag, "_release_valid"}, 16'(out_valid[idx]), 16'd0);
    check({tag, "_release_ready"}, 16'(in_ready[idx]), 16'd1);
  endtask

  initial begin
    int         idx, lat, gap;
    logic [7:0] hi, dv;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      dividend[k] = '0; divisor[k] = '0;
    end
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      check($sformatf("reset%0d_in_ready", k), 16'(in_ready[k]), 16'd1);
      check($sformatf("reset%0d_out_valid", k), 16'(out_valid[k]), 16'd0);
      check($sformatf("reset%0d_q_r", k), {quotient[k], remainder[k]}, 16'h0000);
      check($sformatf("reset%0d_ovf", k), 16'(ovf[k]), 16'd0);
    end

    do_op(0, 16'd1000, 8'd7, 0, "a0_1000_7");
    do_op(1, 16'd1000, 8'd7, 0, "a2_1000_7");
    do_op(0, 16'hFEFF, 8'hFF, 1, "max_fit");
    do_op(0, 16'h0800, 8'h08, 1, "ovf_eq");
    do_op(1, 16'h0800, 8'h08, 0, "a2_ovf_eq");
    do_op(0, 16'h0005, 8'h00, 5, "div0");
    do_op(0, 16'd1000, 8'd7, 5, "backpressure");

    // Continuous out_ready and in_valid: one result every N_ITER+2 cycles.
    in_valid[0] = 1'b1; dividend[0] = 16'd1000; divisor[0] = 8'd7;
    out_ready[0] = 1'b1;
    step();
    wait_valid(0, lat);
    check("thru_first_q", 16'(quotient[0]), 16'd142);
    step();
    gap = 1;
    while (!out_valid[0] && gap < 40) begin
      step();
      gap++;
    end
    check("thru_gap", 16'(gap), 16'd10);
    check("thru_second_q", 16'(quotient[0]), 16'd142);
    in_valid[0] = 1'b0;
    step();
    out_ready[0] = 1'b0;
    step();
    check("thru_idle", 16'(in_ready[0]), 16'd1);

    // Reset during the fourth CALC iteration discards the operation.
    in_valid[0] = 1'b1; dividend[0] = 16'd1000; divisor[0] = 8'd7;
    step();
    in_valid[0] = 1'b0;
    repeat (3) step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    check("rst_mid_out_valid", 16'(out_valid[0]), 16'd0);
    check("rst_mid_in_ready", 16'(in_ready[0]), 16'd1);
    check("rst_mid_quotient", 16'(quotient[0]), 16'd0);
    do_op(0, 16'd100, 8'd3, 0, "after_rst");

    for (int n = 0; n < 24; n++) begin
      idx = int'($urandom_range(0, 1));
      dv  = (n % 8 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
      hi  = (n % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, int'(dv) - 1));
      do_op(idx, {hi, 8'($urandom)}, dv, int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_div16by8_seq.md
Name: approx_div16by8_seq

Overview:
- Sequential 16-by-8 unsigned divider.
- Serves as the inverse-path companion to the 8x8 approximate multipliers. It recovers an 8-bit operand from a 16-bit product and the known 8-bit operand.
- Restoring radix-2 datapath, one quotient bit per cycle. The low APPROX_BITS quotient bits can be skipped, trading accuracy for latency, in the same spirit as the approximate multiplier family.
- valid/ready handshake on both the input and output sides.

Parameters:
- APPROX_BITS, default 0: number of low quotient bits not computed; they are forced to 0. Legal range 0..7.
- N_ITER, derived, 8-APPROX_BITS: number of CALC cycles. Not user-settable.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: dividend and divisor are valid.
- in_ready, output, 1: block can accept an operation.
- dividend, input, 16: unsigned dividend.
- divisor, input, 8: unsigned divisor.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- quotient, output, 8: unsigned quotient, approximate when APPROX_BITS>0.
- remainder, output, 8: partial remainder after the last computed iteration.
- ovf, output, 1: quotient does not fit in 8 bits, or divisor==0.

Behaviour:
- Reset values, with rst high on an edge: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, ovf=0, iteration counter=0.
- rst takes priority over every other event, including mid-CALC and a pending DONE; the in-flight operation is discarded.
- States: IDLE, CALC, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE:
  - On in_valid&in_ready, latch the operands.
  - If dividend[15:8] >= divisor (this covers divisor==0): go to DONE with quotient=0xFF, remainder=0x00, ovf=1. Latency is 1 cycle.
  - Otherwise: load the 9-bit partial remainder P={0,dividend[15:8]}, load the low dividend byte into a shift register, clear counter and quotient, go to CALC.
- CALC, one iteration per cycle:
  - T = {P[7:0], next dividend bit, MSB first}.
  - If T >= divisor: P = T-divisor and shift in quotient bit 1.
  - Else: P = T and shift in 0.
  - Counter increments. After N_ITER iterations go to DONE.
  - In DONE, quotient = computed bits << APPROX_BITS, remainder = P[7:0], ovf=0.
- Latency: accept at cycle T; out_valid first high at T+N_ITER+1 (T+9 when APPROX_BITS=0).
- Exactness:
  - With APPROX_BITS=0, results equal floor(dividend/divisor) and dividend mod divisor.
  - With APPROX_BITS>0, quotient = (dividend>>A)/divisor << A and remainder = (dividend>>A) mod divisor.
- DONE:
  - Outputs are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On out_ready=1, go to IDLE. out_valid drops on the next cycle.
  - Holding out_ready=1 continuously gives one operation per N_ITER+2 cycles.
- Input changes while not in IDLE are ignored. in_valid asserted without in_ready has no effect.
- Arithmetic: comparison and subtraction are 9-bit, with no wrap. P[8] is always 0 after a subtraction; P < divisor is an invariant.

Decomposition:
- Shared package div_pkg holds:
  - state enum {IDLE, CALC, DONE}
  - width constants DW=16, QW=8
  - overflow constants QOVF=8'hFF, ROVF=8'h00
- Sub-module div_step is a combinational one-iteration restoring cell.
  - Inputs: P[7:0], next bit, divisor.
  - Outputs: new P and quotient bit.
  - It is reusable by a future unrolled variant.

Test Plan:
- APPROX_BITS=0, dividend=1000 (0x03E8), divisor=7 -> quotient=142, remainder=6, ovf=0; out_valid exactly 9 cycles after accept.
- APPROX_BITS=2, dividend=1000, divisor=7 -> quotient=140, remainder=5; out_valid 7 cycles after accept.
- dividend=0xFEFF, divisor=0xFF -> quotient=0xFF, remainder=0xFE, ovf=0. dividend=0x0800, divisor=0x08 -> ovf=1, quotient=0xFF, remainder=0x00, out_valid 1 cycle after accept.
- divisor=0, dividend=0x0005 -> ovf=1, quotient=0xFF, remainder=0x00; in_ready stays low until the result is taken.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> outputs unchanged, in_ready=0 throughout; release -> IDLE next cycle; back-to-back random operations checked against a reference model.
- rst asserted during CALC iteration 4 -> next cycle out_valid=0, in_ready=1, quotient=0; a new operation 100/3 then yields quotient=33, remainder=1.
